// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder.
// ADDER_SUB_EN adds the subtract control and overflow flag to the stage control word.
package adder_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  // Per-stage control word; operand remainders and partial sums travel in a separate data vector.
  typedef struct packed {
    logic valid;
    logic carry;
`ifdef ADDER_SUB_EN
    logic sub;
    logic ovf;
`endif
  } stage_t;

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// Input/output streaming bundle of the pipelined adder.
// ADDER_SUB_EN adds sub (with the operands) and ovf (with the sum).
interface pipelined_adder_nbit_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef ADDER_SUB_EN
  logic             sub;
  logic             ovf;

  modport master (output in_valid, x, y, c_in, sub, out_ready,
                  input  in_ready, out_valid, sum, c_out, ovf);
  modport slave  (input  in_valid, x, y, c_in, sub, out_ready,
                  output in_ready, out_valid, sum, c_out, ovf);
`else
  modport master (output in_valid, x, y, c_in, out_ready,
                  input  in_ready, out_valid, sum, c_out);
  modport slave  (input  in_valid, x, y, c_in, out_ready,
                  output in_ready, out_valid, sum, c_out);
`endif
endinterface

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the pipelined adder with its pipeline register.
// Data layout (LSB first): finished sum bits, remaining x bits, remaining y bits.
module adder_stage
  import adder_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 4,
  parameter  int IDX    = 0,
  localparam int CHUNK  = chunk_w(WIDTH, STAGES),
  localparam int IN_W   = 2 * WIDTH - IDX * CHUNK,
  localparam int OUT_W  = IN_W - CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  stage_t           in_ctl,
  input  logic [IN_W-1:0]  in_data,
  output stage_t           out_ctl,
  output logic [OUT_W-1:0] out_data
);

  localparam int REM_OUT = WIDTH - (IDX + 1) * CHUNK;

  logic [CHUNK-1:0] x_slice_s;
  logic [CHUNK-1:0] y_slice_s;
  logic [CHUNK-1:0] y_eff_s;
  logic [CHUNK-1:0] slice_sum_s;
  logic             carry_s;
  logic [OUT_W-1:0] next_data_s;
  stage_t           ctl_d;
  stage_t           ctl_q;
  logic [OUT_W-1:0] data_d;
  logic [OUT_W-1:0] data_q;

  assign x_slice_s = in_data[IDX*CHUNK +: CHUNK];
  assign y_slice_s = in_data[WIDTH +: CHUNK];

`ifdef ADDER_SUB_EN
  logic slice_ovf_s;
  assign y_eff_s     = in_ctl.sub ? ~y_slice_s : y_slice_s;
  // Carry into the slice MSB differs from carry out exactly on signed overflow.
  assign slice_ovf_s = x_slice_s[CHUNK-1] ^ y_eff_s[CHUNK-1] ^ slice_sum_s[CHUNK-1] ^ carry_s;
`else
  assign y_eff_s     = y_slice_s;
`endif

  assign {carry_s, slice_sum_s} = {1'b0, x_slice_s} + {1'b0, y_eff_s}
                                + {{CHUNK{1'b0}}, in_ctl.carry};

  if (IDX == 0) begin : g_lo_first
    if (REM_OUT == 0) begin : g_only
      assign next_data_s = slice_sum_s;
    end else begin : g_rem
      assign next_data_s = {in_data[WIDTH+CHUNK +: REM_OUT], in_data[CHUNK +: REM_OUT], slice_sum_s};
    end
  end else begin : g_lo_acc
    if (REM_OUT == 0) begin : g_last
      assign next_data_s = {slice_sum_s, in_data[IDX*CHUNK-1:0]};
    end else begin : g_mid
      assign next_data_s = {in_data[WIDTH+CHUNK +: REM_OUT], in_data[(IDX+1)*CHUNK +: REM_OUT],
                            slice_sum_s, in_data[IDX*CHUNK-1:0]};
    end
  end

  // Bubbles move the valid bit but leave data untouched, so the output holds between results.
  always_comb begin
    ctl_d  = ctl_q;
    data_d = data_q;
    if (advance) begin
      ctl_d.valid = in_ctl.valid;
      if (in_ctl.valid) begin
        ctl_d.carry = carry_s;
`ifdef ADDER_SUB_EN
        ctl_d.sub   = in_ctl.sub;
        ctl_d.ovf   = (IDX == STAGES - 1) ? slice_ovf_s : in_ctl.ovf;
`endif
        data_d      = next_data_s;
      end else begin
        data_d      = data_q;
      end
    end else begin
      ctl_d  = ctl_q;
      data_d = data_q;
    end
  end

  // Stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q  <= '0;
      data_q <= '0;
    end else begin
      ctl_q  <= ctl_d;
      data_q <= data_d;
    end
  end

  assign out_ctl  = ctl_q;
  assign out_data = data_q;

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit ripple-carry adder, one CHUNK slice per stage, valid/ready on both sides.
// Define ADDER_SUB_EN for the subtract input and signed-overflow output.
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic rst,
  pipelined_adder_nbit_if.slave bus
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "pipelined_adder_nbit: STAGES must be at least 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $fatal(1, "pipelined_adder_nbit: WIDTH must be a multiple of STAGES");
  end

  logic             advance_s;
  stage_t           first_ctl_s;
  stage_t           last_ctl_s;
  logic [WIDTH-1:0] last_data_s;

  // The whole pipe moves together whenever the output slot is free or being drained.
  assign advance_s   = !last_ctl_s.valid || bus.out_ready;
  assign bus.in_ready = advance_s;

  // Stage-0 control word; subtraction forces the carry-in that completes the two's complement.
  always_comb begin
    first_ctl_s       = '0;
    first_ctl_s.valid = bus.in_valid;
`ifdef ADDER_SUB_EN
    first_ctl_s.sub   = bus.sub;
    first_ctl_s.ovf   = 1'b0;
    if (bus.sub) begin
      first_ctl_s.carry = 1'b1;
    end else begin
      first_ctl_s.carry = bus.c_in;
    end
`else
    first_ctl_s.carry = bus.c_in;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W  = 2 * WIDTH - k * CHUNK;
    localparam int OUT_W = IN_W - CHUNK;

    stage_t           ctl_in;
    stage_t           ctl_out;
    logic [IN_W-1:0]  data_in;
    logic [OUT_W-1:0] data_out;

    if (k == 0) begin : g_first
      assign ctl_in  = first_ctl_s;
      assign data_in = {bus.y, bus.x};
    end else begin : g_next
      assign ctl_in  = g_stage[k-1].ctl_out;
      assign data_in = g_stage[k-1].data_out;
    end

    adder_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance_s),
      .in_ctl   (ctl_in),
      .in_data  (data_in),
      .out_ctl  (ctl_out),
      .out_data (data_out)
    );
  end

  assign last_ctl_s  = g_stage[STAGES-1].ctl_out;
  assign last_data_s = g_stage[STAGES-1].data_out;

  assign bus.out_valid = last_ctl_s.valid;
  assign bus.sum       = last_data_s;
  assign bus.c_out     = last_ctl_s.carry;
`ifdef ADDER_SUB_EN
  assign bus.ovf       = last_ctl_s.ovf;
`endif

endmodule
